id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction Decode stage of the core_lapido 5-stage pipeline. Consumes instruction/pc from the fetch
//  stage, reads the register file, decodes control, and registers everything into the ID/EX boundary.
//  Drives the fetch stage back: is_jump/jump_addr for J/JAL, and stall_pipeline on a load-use hazard.
//  Owns the architectural register file; the WB stage writes it through the wb_* port.
// PARAMETERS
//  PC_WIDTH     32  program-counter width (word-addressed, pc+1 = next instruction)
//  DATA_WIDTH   32  register/datapath width; instruction width fixed at 32
//  NUM_REGS     32  register count; index width = 5
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  instruction     in   32  IF/ID instruction (NOP_INSTRUCTION = 32'h0 is a bubble)
//  pc              in   PC  IF/ID pc of that instruction
//  branch_taken    in   1   from MEM: branch resolved taken, flush younger work
//  wb_we           in   1   write-back enable
//  wb_addr         in   5   write-back register index
//  wb_data         in   DW  write-back data
//  is_jump         out  1   to IF: redirect to jump_addr this edge (combinational)
//  jump_addr       out  PC  {pc[PC-1:26], instruction[25:0]} (combinational)
//  stall_pipeline  out  1   to IF/hazard: hold pc, insert bubble (combinational)
//  ex_pc           out  PC  registered pc
//  ex_rs_data      out  DW  registered rs value;  ex_rt_data out DW registered rt value
//  ex_imm          out  DW  registered sign-extended imm16
//  ex_rs, ex_rt    out  5   registered source indices (for forwarding)
//  ex_rd_dst       out  5   registered destination (rd for R-type, rt for I-type, 31 for JAL)
//  ex_alu_op       out  6   registered funct (R-type) or opcode (I-type)
//  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_alu_src_imm, ex_link  out 1 each
// BEHAVIOUR
//  Fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0] target[25:0].
//  Opcodes: R 00, J 02, JAL 03, BEQ 04, BNE 05, ADDI 08, LW 23, SW 2B; any other -> treated as NOP (all ctrl 0).
//  Reset: every ex_* output 0; register file all 0. Reset mid-operation clears both at once.
//  Latency: 1 cycle, instruction at IF/ID on edge N appears on ex_* after edge N.
//  Register file: r0 reads 0, writes to r0 ignored; write at posedge; same-cycle read of wb_addr
//   returns wb_data (write-through bypass) when wb_we && wb_addr!=0.
//  Load-use: stall_pipeline = ex_mem_read && ex_rd_dst!=0 && (ex_rd_dst==rs || (uses_rt && ex_rd_dst==rt));
//   uses_rt for R, BEQ, BNE, SW. On stall: ID/EX loads bubble (all ctrl 0), IF/ID holds (IF side).
//  is_jump = (op==J||op==JAL) && !stall_pipeline && !branch_taken.
//  JAL: ex_link=1, ex_reg_write=1, ex_rd_dst=31, ex_pc=pc (EX writes pc+1).
//  Flush: branch_taken at edge -> ID/EX loads bubble regardless of decode; branch_taken wins over stall.
//  Bubble = all control bits 0, data fields don't-care but driven 0.
//  Width rules: ex_imm = {{DW-16{imm[15]}}, imm}; jump_addr takes upper pc bits from current pc.
// STRUCTURE
//  lapido_defs.v: opcode constants, field bit positions, PC_WIDTH, NOP_INSTRUCTION, REG_ADDR_WIDTH.
//  One sub-module: register_file (2 async read, 1 sync write, r0 zero, write-through bypass).
//  Decode and hazard logic combinational in id_stage; single ID/EX always block with async reset.
// TESTING
//  ADDI r1,r0,-5 (op 08, imm FFFB) -> next edge ex_imm=32'hFFFFFFFB, ex_rd_dst=1, alu_src_imm=1, reg_write=1.
//  wb_we=1 wb_addr=3 wb_data=0xDEAD with R-type reading rs=3 same cycle -> ex_rs_data=0xDEAD; wb_addr=0 -> reads 0.
//  LW r2 then ADD r4,r2,r5 -> stall_pipeline=1 one cycle, ID/EX bubble, then ADD issues with stall=0.
//  JAL target 0x10 at pc=0x20 -> is_jump=1, jump_addr=0x10; ex_link=1, ex_rd_dst=31, ex_pc=0x20.
//  branch_taken=1 coincident with J and with load-use stall -> is_jump=0, ID/EX bubble, no stall-hold effect.
//  rst asserted mid-stream with ex_reg_write=1 -> all ex_* 0 immediately, r1..r31 read 0 after release.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the core_lapido ID stage:
// opcodes, field positions, widths and the ID/EX control bundle.
package id_stage_pkg;

  localparam int PC_WIDTH       = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int INSTR_WIDTH    = 32;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = '0;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int TARGET_W  = 26;
  localparam int IMM_W     = 16;

  localparam logic [REG_ADDR_WIDTH-1:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
    logic alu_src_imm;
    logic link;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Instructions whose rt field is a source operand
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_R) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// Architectural register file: two async reads, one sync write,
// r0 hard-wired to zero, same-cycle write-through to the readers.
module register_file
  import id_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]         raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == '0) begin
      rdata_a_o = '0;
    end else if (wr_en && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == '0) begin
      rdata_b_o = '0;
    end else if (wr_en && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// core_lapido decode stage: register read, control decode,
// load-use hazard detection, jump redirect and the ID/EX register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int PC_WIDTH   = id_stage_pkg::PC_WIDTH,
  parameter int DATA_WIDTH = id_stage_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = id_stage_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INSTR_WIDTH-1:0]    instruction,
  input  logic [PC_WIDTH-1:0]       pc,
  input  logic                      branch_taken,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      is_jump,
  output logic [PC_WIDTH-1:0]       jump_addr,
  output logic                      stall_pipeline,
  output logic [PC_WIDTH-1:0]       ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_rs_data,
  output logic [DATA_WIDTH-1:0]     ex_rt_data,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_dst,
  output logic [5:0]                ex_alu_op,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch,
  output logic                      ex_branch_ne,
  output logic                      ex_alu_src_imm,
  output logic                      ex_link
);

  logic [5:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [5:0]                funct;
  logic [IMM_W-1:0]          imm;
  logic [TARGET_W-1:0]       target;

  assign op     = instruction[OP_LSB +: 6];
  assign rs     = instruction[RS_LSB +: REG_ADDR_WIDTH];
  assign rt     = instruction[RT_LSB +: REG_ADDR_WIDTH];
  assign rd     = instruction[RD_LSB +: REG_ADDR_WIDTH];
  assign funct  = instruction[5:0];
  assign imm    = instruction[IMM_W-1:0];
  assign target = instruction[TARGET_W-1:0];

  logic [DATA_WIDTH-1:0] rs_rdata;
  logic [DATA_WIDTH-1:0] rt_rdata;

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .AW         (REG_ADDR_WIDTH)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs),
    .rdata_a_o (rs_rdata),
    .raddr_b_i (rt),
    .rdata_b_o (rt_rdata),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  ctrl_t                     ctrl_q,    ctrl_d;
  logic [PC_WIDTH-1:0]       pc_q,      pc_d;
  logic [DATA_WIDTH-1:0]     rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0]     rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,     imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q,      rs_d;
  logic [REG_ADDR_WIDTH-1:0] rt_q,      rt_d;
  logic [REG_ADDR_WIDTH-1:0] dst_q,     dst_d;
  logic [5:0]                aop_q,     aop_d;

  // Older load in EX whose result this instruction needs
  assign stall_pipeline = ctrl_q.mem_read && (dst_q != '0) &&
                          ((dst_q == rs) ||
                           (uses_rt(op) && (dst_q == rt)));

  assign is_jump   = ((op == OP_J) || (op == OP_JAL)) &&
                     !stall_pipeline && !branch_taken;
  assign jump_addr = {pc[PC_WIDTH-1:TARGET_W], target};

  ctrl_t                     dec_ctrl;
  logic [REG_ADDR_WIDTH-1:0] dec_dst;
  logic [5:0]                dec_aop;
  logic                      dec_valid;

  always_comb begin
    dec_ctrl  = CTRL_NONE;
    dec_dst   = '0;
    dec_aop   = op;
    dec_valid = 1'b1;
    unique case (1'b1)
      (op == OP_R): begin
        dec_ctrl.reg_write = 1'b1;
        dec_dst            = rd;
        dec_aop            = funct;
      end
      (op == OP_J): begin
      end
      (op == OP_JAL): begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.link      = 1'b1;
        dec_dst            = LINK_REG;
      end
      (op == OP_BEQ): begin
        dec_ctrl.branch = 1'b1;
      end
      (op == OP_BNE): begin
        dec_ctrl.branch    = 1'b1;
        dec_ctrl.branch_ne = 1'b1;
      end
      (op == OP_ADDI): begin
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_dst              = rt;
      end
      (op == OP_LW): begin
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.mem_read    = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_dst              = rt;
      end
      (op == OP_SW): begin
        dec_ctrl.mem_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
    if (instruction == NOP_INSTRUCTION) begin
      dec_valid = 1'b0;
    end
  end

  // Flush, stall and unknown opcodes all become a fully zeroed bubble
  always_comb begin
    ctrl_d    = CTRL_NONE;
    pc_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    dst_d     = '0;
    aop_d     = '0;
    if (dec_valid && !branch_taken && !stall_pipeline) begin
      ctrl_d    = dec_ctrl;
      pc_d      = pc;
      rs_data_d = rs_rdata;
      rt_data_d = rt_rdata;
      imm_d     = {{(DATA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
      rs_d      = rs;
      rt_d      = rt;
      dst_d     = dec_dst;
      aop_d     = dec_aop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= CTRL_NONE;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dst_q     <= '0;
      aop_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dst_q     <= dst_d;
      aop_q     <= aop_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_rs_data     = rs_data_q;
  assign ex_rt_data     = rt_data_q;
  assign ex_imm         = imm_q;
  assign ex_rs          = rs_q;
  assign ex_rt          = rt_q;
  assign ex_rd_dst      = dst_q;
  assign ex_alu_op      = aop_q;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_branch      = ctrl_q.branch;
  assign ex_branch_ne   = ctrl_q.branch_ne;
  assign ex_alu_src_imm = ctrl_q.alu_src_imm;
  assign ex_link        = ctrl_q.link;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random instruction
// streams checked against a behavioural decode/hazard model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        branch_taken;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        is_jump;
  logic [31:0] jump_addr;
  logic        stall_pipeline;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd_dst;
  logic [5:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_branch_ne;
  logic        ex_alu_src_imm;
  logic        ex_link;

  id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .instruction    (instruction),
    .pc             (pc),
    .branch_taken   (branch_taken),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .is_jump        (is_jump),
    .jump_addr      (jump_addr),
    .stall_pipeline (stall_pipeline),
    .ex_pc          (ex_pc),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd_dst      (ex_rd_dst),
    .ex_alu_op      (ex_alu_op),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_branch_ne   (ex_branch_ne),
    .ex_alu_src_imm (ex_alu_src_imm),
    .ex_link        (ex_link)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [5:0]  aop;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mrf [32];
  exp_t        mex;
  exp_t        zero_e;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_ex(input exp_t e);
    chk("ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                 ex_branch_ne, ex_alu_src_imm, ex_link}, e.ctrl);
    chk("ex_pc", ex_pc, e.pc);
    chk("ex_rs_data", ex_rs_data, e.rsd);
    chk("ex_rt_data", ex_rt_data, e.rtd);
    chk("ex_imm", ex_imm, e.imm);
    chk("ex_rs", ex_rs, e.rs);
    chk("ex_rt", ex_rt, e.rt);
    chk("ex_rd_dst", ex_rd_dst, e.dst);
    chk("ex_alu_op", ex_alu_op, e.aop);
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a,
      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return mrf[a];
  endfunction

  // One pipeline cycle: drive, check combinational outputs, clock, check ID/EX
  task automatic step(input logic [31:0] ins, input logic [31:0] p,
                      input logic bt, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       need_rt, stall, known, jmp;
    exp_t       n;
    @(negedge clk);
    instruction = ins; pc = p; branch_taken = bt;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    need_rt = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
    stall = mex.ctrl[5] && mex.dst != 0 &&
            (mex.dst == rs || (need_rt && mex.dst == rt));
    jmp = (op == 6'h02 || op == 6'h03) && !stall && !bt;
    chk("stall_pipeline", stall_pipeline, stall);
    chk("is_jump", is_jump, jmp);
    if (op == 6'h02 || op == 6'h03)
      chk("jump_addr", jump_addr, {p[31:26], ins[25:0]});
    n = zero_e;
    known = 1'b1;
    n.aop = op;
    case (op)
      6'h00: begin n.ctrl = 7'b1000000; n.dst = ins[15:11]; n.aop = ins[5:0]; end
      6'h02: ;
      6'h03: begin n.ctrl = 7'b1000001; n.dst = 31; end
      6'h04: n.ctrl = 7'b0001000;
      6'h05: n.ctrl = 7'b0001100;
      6'h08: begin n.ctrl = 7'b1000010; n.dst = rt; end
      6'h23: begin n.ctrl = 7'b1100010; n.dst = rt; end
      6'h2B: n.ctrl = 7'b0010010;
      default: known = 1'b0;
    endcase
    if (known && ins != 0 && !bt && !stall) begin
      n.pc  = p;
      n.rsd = rd_model(rs, we, wa, wd);
      n.rtd = rd_model(rt, we, wa, wd);
      n.imm = {{16{ins[15]}}, ins[15:0]};
      n.rs  = rs;
      n.rt  = rt;
    end else begin
      n = zero_e;
    end
    last_stall = stall;
    @(posedge clk);
    if (we && wa != 0) mrf[wa] = wd;
    mex = n;
    #1;
    check_ex(mex);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [9];
    logic [31:0] r;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F};
    r = $urandom;
    r[31:26] = ops[$urandom_range(0, 8)];
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    r[15:11] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 19) == 0) r = 0;
    return r;
  endfunction

  initial begin
    logic [31:0] ins, p;
    logic        bt;
    zero_e = '{ctrl: 0, pc: 0, rsd: 0, rtd: 0, imm: 0,
               rs: 0, rt: 0, dst: 0, aop: 0};
    mex = zero_e;
    last_stall = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    rst = 1'b1;
    instruction = 32'h0; pc = 0; branch_taken = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check_ex(zero_e);
    @(negedge clk);
    rst = 1'b0;

    // ADDI r1,r0,-5
    step({6'h08, 5'd0, 5'd1, 16'hFFFB}, 32'h100, 0, 0, 0, 0);
    chk("addi_imm", ex_imm, 32'hFFFFFFFB);
    chk("addi_dst", ex_rd_dst, 5'd1);

    // Write-through bypass, and r0 stays zero
    step({6'h00, 5'd3, 5'd0, 5'd4, 5'd0, 6'h20}, 32'h104, 0, 1, 3, 32'hDEAD);
    chk("bypass_rs", ex_rs_data, 32'hDEAD);
    step({6'h00, 5'd0, 5'd3, 5'd4, 5'd0, 6'h20}, 32'h108, 0, 1, 0, 32'hBEEF);
    chk("r0_read", ex_rs_data, 32'h0);
    chk("r3_kept", ex_rt_data, 32'hDEAD);

    // LW r2 then ADD r4,r2,r5
    step({6'h23, 5'd0, 5'd2, 16'h0004}, 32'h10C, 0, 0, 0, 0);
    step({6'h00, 5'd2, 5'd5, 5'd4, 5'd0, 6'h20}, 32'h110, 0, 0, 0, 0);
    chk("lu_stall", last_stall, 1'b1);
    chk("lu_bubble", ex_reg_write, 1'b0);
    step({6'h00, 5'd2, 5'd5, 5'd4, 5'd0, 6'h20}, 32'h110, 0, 0, 0, 0);
    chk("lu_release", last_stall, 1'b0);
    chk("lu_add_dst", ex_rd_dst, 5'd4);

    // JAL target 0x10 at pc 0x20
    step({6'h03, 26'h10}, 32'h20, 0, 0, 0, 0);
    chk("jal_link", ex_link, 1'b1);
    chk("jal_dst", ex_rd_dst, 5'd31);
    chk("jal_pc", ex_pc, 32'h20);

    // Flush on J and on a stalled load-use
    step({6'h02, 26'h55}, 32'h24, 1, 0, 0, 0);
    chk("flush_j", ex_pc, 32'h0);
    step({6'h23, 5'd0, 5'd2, 16'h0000}, 32'h28, 0, 0, 0, 0);
    step({6'h00, 5'd2, 5'd5, 5'd4, 5'd0, 6'h20}, 32'h2C, 1, 0, 0, 0);
    chk("flush_stall_rw", ex_reg_write, 1'b0);

    // Random stream; IF holds the instruction while stalled
    ins = rand_instr(); p = $urandom; bt = 0;
    for (int c = 0; c < 300; c++) begin
      if (!(last_stall && !bt)) begin
        ins = rand_instr(); p = $urandom;
      end
      bt = ($urandom_range(0, 9) == 0);
      step(ins, p, bt, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom);
    end

    // Fill every register, then reset mid-stream
    for (int i = 1; i < 32; i++)
      step(32'h0, 0, 0, 1, 5'(i), 32'h1000 + i);
    step({6'h08, 5'd1, 5'd1, 16'h0007}, 32'h40, 0, 0, 0, 0);
    chk("pre_rst_rw", ex_reg_write, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ex(zero_e);
    mex = zero_e;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      step({6'h00, 5'(i), 5'(i), 5'd1, 5'd0, 6'h20}, 32'h80, 0, 0, 0, 0);
      chk("post_rst_rd", ex_rs_data, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
